// File: rtl/die_select_latch.sv
// Debounced, latching die-select: synchronises and debounces each button, then
// latches the index of a clean single press and strobes selValid for one cycle.
module die_select_latch #(
  parameter int NUM_BUTTONS     = 7,
  parameter int SEL_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [SEL_WIDTH-1:0]   dieSelect,
  output logic                   selValid,
  output logic                   selConflict,
  output logic                   selBusy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESSED  = 2'd1,
    CONFLICT = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  state_t                 state_q;
  logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
  logic [NUM_BUTTONS-1:0] deb_q, deb_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_BUTTONS];
  logic [CNT_WIDTH-1:0]   cnt_d [NUM_BUTTONS];
  logic [SEL_WIDTH-1:0]   sel_q;
  logic                   valid_q, conflict_q, busy_q;

  logic                   none, multi, onehot, same_held;
  logic [SEL_WIDTH-1:0]   idx;

  // A channel's stable level flips only after DEBOUNCE_CYCLES consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    none  = (deb_q == '0);
    multi = |(deb_q & (deb_q - NUM_BUTTONS'(1)));
    onehot = !none && !multi;
    idx = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (deb_q[i]) idx = SEL_WIDTH'(i);
    end
    // In PRESSED, anything other than the latched button alone is a conflict.
    same_held = onehot && (idx == sel_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= buttons;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sel_q      <= '1;
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      conflict_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (onehot) begin
            state_q <= PRESSED;
            sel_q   <= idx;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (multi) begin
            state_q    <= CONFLICT;
            conflict_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        PRESSED: begin
          if (none) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (!same_held) begin
            state_q    <= CONFLICT;
            conflict_q <= 1'b1;
          end
        end
        CONFLICT: begin
          if (none) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dieSelect   = sel_q;
  assign selValid    = valid_q;
  assign selConflict = conflict_q;
  assign selBusy     = busy_q;

endmodule

// File: tb/tb_die_select_latch.sv
// Bench for die_select_latch: a cycle model checked every cycle, plus directed
// scenarios with hand-computed latencies (DEBOUNCE_CYCLES = 4, so 6 edges).
module tb_die_select_latch;

  localparam int N  = 7;
  localparam int SW = 4;
  localparam int DC = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  buttons = '0;
  logic [SW-1:0] dieSelect;
  logic          selValid, selConflict, selBusy;

  always #5 clk = ~clk;

  die_select_latch #(
    .NUM_BUTTONS(N), .SEL_WIDTH(SW), .DEBOUNCE_CYCLES(DC), .CNT_WIDTH(3)
  ) dut (
    .clk(clk), .reset(reset), .buttons(buttons), .dieSelect(dieSelect),
    .selValid(selValid), .selConflict(selConflict), .selBusy(selBusy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  int n_conf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stage view: raw -> two sample delays -> level accepted after DC disagreeing
  // samples in a row -> selection rules applied to the accepted levels.
  localparam int S_IDLE = 0, S_PRESSED = 1, S_CONFLICT = 2;
  bit [N-1:0]    m_s1, m_s2, m_deb;
  int            m_run [N];
  int            m_state;
  logic [SW-1:0] m_sel;
  bit            m_valid, m_conf;
  int            m_n;

  function automatic logic [SW-1:0] idx_of(input bit [N-1:0] v);
    idx_of = '0;
    for (int i = 0; i < N; i++) if (v[i]) idx_of = SW'(i);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_state = S_IDLE; m_sel = '1; m_valid = 0; m_conf = 0;
    end else begin
      m_valid = 0;
      m_conf  = 0;
      m_n = $countones(m_deb);
      case (m_state)
        S_IDLE: begin
          if (m_n == 1) begin
            m_state = S_PRESSED; m_sel = idx_of(m_deb); m_valid = 1;
          end else if (m_n > 1) begin
            m_state = S_CONFLICT; m_conf = 1;
          end
        end
        S_PRESSED: begin
          if (m_n == 0) m_state = S_IDLE;
          else if (m_deb != (7'b1 << m_sel)) begin
            m_state = S_CONFLICT; m_conf = 1;
          end
        end
        default: if (m_n == 0) m_state = S_IDLE;
      endcase
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == DC) begin
            m_deb[i] = ~m_deb[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = buttons;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin
    #1;
    check("dieSelect", dieSelect, m_sel);
    check("selValid", selValid, m_valid);
    check("selConflict", selConflict, m_conf);
    check("selBusy", selBusy, (m_state != S_IDLE));
    if (selValid) n_valid++;
    if (selConflict) n_conf++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic to_edge(input int k);
    repeat (k + 1) @(posedge clk);
    #1;
  endtask

  task automatic press_release(input int b);
    @(negedge clk) buttons[b] = 1'b1;
    wait_neg(10);
    buttons[b] = 1'b0;
    wait_neg(10);
  endtask

  int vc, cc;

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", dieSelect, 4'hF);
    check("rst_busy", selBusy, 1'b0);
    @(negedge clk) reset = 1'b0;
    wait_neg(3);

    // single press on button 2, 6-edge latency
    buttons[2] = 1'b1;
    to_edge(5);
    check("p2_e5_valid", selValid, 1'b0);
    check("p2_e5_sel", dieSelect, 4'hF);
    to_edge(0);
    check("p2_e6_valid", selValid, 1'b1);
    check("p2_e6_sel", dieSelect, 4'b0010);
    to_edge(0);
    check("p2_e7_valid", selValid, 1'b0);
    wait_neg(13);
    buttons[2] = 1'b0;
    to_edge(5);
    check("r2_e5_busy", selBusy, 1'b1);
    to_edge(0);
    check("r2_e6_busy", selBusy, 1'b0);
    check("r2_sel_hold", dieSelect, 4'b0010);

    // 3-cycle glitch on button 5
    @(negedge clk) vc = n_valid;
    buttons[5] = 1'b1;
    wait_neg(3);
    buttons[5] = 1'b0;
    wait_neg(15);
    check("glitch_valids", n_valid - vc, 0);
    check("glitch_sel", dieSelect, 4'b0010);
    check("glitch_busy", selBusy, 1'b0);

    // reselect and hold
    vc = n_valid;
    press_release(0);
    check("sel_b0", dieSelect, 4'b0000);
    press_release(6);
    check("sel_b6", dieSelect, 4'b0110);
    wait_neg(100);
    check("hold_b6", dieSelect, 4'b0110);
    check("hold_valids", n_valid - vc, 2);

    // conflict while pressed
    vc = n_valid; cc = n_conf;
    buttons[1] = 1'b1;
    wait_neg(10);
    check("cf_sel1", dieSelect, 4'b0001);
    check("cf_valid1", n_valid - vc, 1);
    buttons[3] = 1'b1;
    wait_neg(10);
    check("cf_conf", n_conf - cc, 1);
    check("cf_sel_keep", dieSelect, 4'b0001);
    buttons[1] = 1'b0;
    wait_neg(10);
    check("cf_no_valid", n_valid - vc, 1);
    check("cf_busy", selBusy, 1'b1);
    buttons = '0;
    wait_neg(10);
    check("cf_idle", selBusy, 1'b0);

    // simultaneous press straight after reset
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    wait_neg(3);
    vc = n_valid; cc = n_conf;
    buttons = 7'b0010001;
    to_edge(5);
    check("sim_e5_conf", selConflict, 1'b0);
    to_edge(0);
    check("sim_e6_conf", selConflict, 1'b1);
    check("sim_e6_valid", selValid, 1'b0);
    check("sim_sel", dieSelect, 4'hF);
    @(negedge clk) buttons = '0;
    wait_neg(10);
    check("sim_valids", n_valid - vc, 0);
    check("sim_confs", n_conf - cc, 1);

    // reset while button 3 is held
    buttons[3] = 1'b1;
    wait_neg(10);
    check("rm_sel3", dieSelect, 4'b0011);
    reset = 1'b1;
    #1;
    check("rm_async_sel", dieSelect, 4'hF);
    check("rm_async_busy", selBusy, 1'b0);
    @(negedge clk) reset = 1'b0;
    vc = n_valid;
    to_edge(5);
    check("rm_e5_sel", dieSelect, 4'hF);
    check("rm_e5_valid", selValid, 1'b0);
    to_edge(0);
    check("rm_e6_sel", dieSelect, 4'b0011);
    check("rm_e6_valid", selValid, 1'b1);
    @(negedge clk) buttons = '0;
    wait_neg(10);
    check("rm_valids", n_valid - vc, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/die_select_latch.md
# die_select_latch

Parametrised, debounced, latching successor to the combinational die-select encoder. It takes NUM_BUTTONS raw asynchronous push-buttons, synchronises and debounces each one, and accepts only a clean single-button press. It then latches the button's index as a held selection code and emits a one-cycle strobe. It sits between the board buttons and the roll logic, which consumes dieSelect and selValid.

## Interface

- NUM_BUTTONS, 7: number of button channels; must satisfy 1 <= NUM_BUTTONS <= 2^SEL_WIDTH - 1.
- SEL_WIDTH, 4: width of the selection code.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required to accept a level change; must be >= 1.
- CNT_WIDTH, 5: debounce counter width; must hold DEBOUNCE_CYCLES.

- clk, input, 1: single clock, rising-edge.
- reset, input, 1: asynchronous, active-high reset.
- buttons, input, NUM_BUTTONS: raw asynchronous buttons, active-high. Bit i is channel i (bit 0 = D4, ascending).
- dieSelect, output, SEL_WIDTH: latched index of the last accepted button; all-ones = no selection.
- selValid, output, 1: one-cycle pulse when dieSelect is (re)loaded.
- selConflict, output, 1: one-cycle pulse when more than one button becomes debounced-down.
- selBusy, output, 1: high while the FSM is not IDLE.

## Operation

- **Per-channel synchroniser:** two flops, sync1 then sync2. No logic is placed between them.
- **Per-channel debounce:**
  - The stable bit deb[i] and counter cnt[i] are tracked per channel.
  - If sync2[i] == deb[i], cnt[i] is cleared to 0.
  - Otherwise cnt[i] increments. When cnt[i] == DEBOUNCE_CYCLES-1 on that edge, deb[i] toggles and cnt[i] clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches deb.
- **onehot** = deb has exactly one bit set. idx = position of that bit. **none** = deb all zero.
- **FSM states** (IDLE, PRESSED, CONFLICT), evaluated on deb:
  - IDLE, onehot: go to PRESSED. dieSelect <= idx, selValid = 1.
  - IDLE, deb has more than one bit set: go to CONFLICT. selConflict = 1, dieSelect unchanged.
  - IDLE, none: stay in IDLE.
  - PRESSED, none: go to IDLE.
  - PRESSED, any additional bit set: go to CONFLICT. selConflict = 1, dieSelect keeps its value.
  - PRESSED, same onehot held: stay in PRESSED. No new strobe.
  - CONFLICT: stays until none, then goes to IDLE. Releasing down to a single button does not select.
- **Selection hold:** dieSelect holds indefinitely. It changes only on an IDLE to PRESSED transition. Re-pressing the same button re-strobes selValid with the same code.
- **Code:** dieSelect = idx zero-extended to SEL_WIDTH. The all-ones code is never produced by a press.
- **selBusy** = (state != IDLE).

## Timing

- **Reset values** (asynchronous assertion, all flops): sync/deb/cnt = 0, state = IDLE, dieSelect = all-ones, selValid = 0, selConflict = 0, selBusy = 0.
- **Reset mid-press:** state returns to IDLE and deb clears. A button still held after reset release is debounced afresh and produces one selValid after full latency.
- **All outputs are registered.**
- **Latency:** raw press first sampled at edge 0, then:
  - sync2 rises at edge 1.
  - deb rises at edge DEBOUNCE_CYCLES+1.
  - dieSelect/selValid update at edge DEBOUNCE_CYCLES+2.
  - Release uses the same latency to return to IDLE.
- **Pulse width:** selValid and selConflict are exactly one cycle wide and never asserted together.
- **Simultaneous debounce:** if two channels debounce on the same edge from IDLE, the FSM goes straight to CONFLICT with no selValid.
- **Press during release:** a new press while in PRESSED, before the prior button has debounced released, is a conflict.
- **Counter behaviour:** the counter never wraps; CNT_WIDTH is sized so DEBOUNCE_CYCLES-1 fits.

## Test plan

Benches use DEBOUNCE_CYCLES=4.

- **Reset and single press:** reset, then press buttons[2] and hold for 20 cycles. Required: dieSelect = 4'b1111 during and after reset; dieSelect = 4'b0010 and one selValid pulse exactly 6 edges after the press; selBusy = 1 until 6 edges after release.
- **Glitch rejection:** pulse buttons[5] high for 3 cycles. Required: no selValid, dieSelect unchanged, selBusy stays 0.
- **Reselect and hold:**
  - Press/release buttons[0]. Required: dieSelect = 0000.
  - Then press/release buttons[6]. Required: dieSelect = 0110.
  - Wait 100 cycles. Required: dieSelect stays 0110; exactly 2 selValid pulses in total.
- **Conflict while pressed:**
  - Hold buttons[1]. Required: dieSelect = 0001, selValid pulse.
  - Add buttons[3]. Required: one selConflict pulse, dieSelect stays 0001.
  - Release buttons[1] only. Required: no selValid.
  - Release all. Required: selBusy drops.
- **Simultaneous press:** press buttons[0] and buttons[4] on the same cycle. Required: selConflict pulse 6 edges later, no selValid, dieSelect stays 1111.
- **Reset mid-press:** assert reset while buttons[3] is held in PRESSED, then release reset with the button still held. Required: dieSelect = 1111 immediately; dieSelect = 0011 with one selValid 6 edges after reset release.
